// File: rtl/golden_nonce_uart_tx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// golden_nonce_uart_tx_if : nonce capture strobe and UART reporter status
// Revision: 1.0
// ---------------------------------------------------------------------------
interface golden_nonce_uart_tx_if #(
  parameter int FIFO_DEPTH_LOG2 = 2
);
  logic                     nonce_valid;
  logic [31:0]              nonce;
  logic                     txd;
  logic                     busy;
  logic                     overflow;
  logic [FIFO_DEPTH_LOG2:0] fifo_count;

  modport master (
    output nonce_valid, nonce,
    input  txd, busy, overflow, fifo_count
  );

  modport slave (
    input  nonce_valid, nonce,
    output txd, busy, overflow, fifo_count
  );
endinterface
`default_nettype wire

// File: rtl/golden_nonce_uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// golden_nonce_uart_tx : queues golden nonces and sends them MSB byte first
// over a UART 8N1 line.  Revision: 1.0
// ---------------------------------------------------------------------------
module golden_nonce_uart_tx #(
  parameter int CLK_DIV         = 868,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  golden_nonce_uart_tx_if.slave bus
);
  localparam logic [FIFO_DEPTH_LOG2:0]   c_FULL    = (FIFO_DEPTH_LOG2+1)'(1 << FIFO_DEPTH_LOG2);
  localparam logic [FIFO_DEPTH_LOG2:0]   c_CNT_ONE = (FIFO_DEPTH_LOG2+1)'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] c_PTR_ONE = (FIFO_DEPTH_LOG2)'(1);
  localparam logic [15:0]                c_DIV_LAST = 16'(CLK_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [31:0]                mem_q [1 << FIFO_DEPTH_LOG2];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
  logic                       overflow_q;

  logic [1:0]  state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] div_q, div_d;
  logic        txd_q, txd_d;

  logic w_empty, w_full, w_pop, w_push, w_drop, w_bit_end;
  logic [31:0] w_head;

  assign w_empty   = (count_q == '0);
  assign w_full    = (count_q == c_FULL);
  assign w_pop     = (state_q == S_IDLE) && !w_empty;
  // A full FIFO still accepts a push on the edge that frees a slot.
  assign w_push    = bus.nonce_valid && (!w_full || w_pop);
  assign w_drop    = bus.nonce_valid && !w_push;
  assign w_bit_end = (div_q == '0);
  assign w_head    = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop)
      count_d = count_q + c_CNT_ONE;
    else if (!w_push && w_pop)
      count_d = count_q - c_CNT_ONE;
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    div_d      = div_q;
    txd_d      = txd_q;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (w_pop) begin
          word_d     = w_head;
          byte_idx_d = 2'd0;
          shift_d    = w_head[31:24];
          div_d      = c_DIV_LAST;
          txd_d      = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          bit_idx_d = 3'd0;
          div_d     = c_DIV_LAST;
          txd_d     = shift_q[0];
          state_d   = S_DATA;
        end else begin
          div_d = div_q - 16'd1;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          div_d   = c_DIV_LAST;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end else begin
          div_d = div_q - 16'd1;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (byte_idx_q != 2'd3) begin
            // Rotating the word keeps the next byte to send in [23:16].
            word_d     = {word_q[23:0], word_q[31:24]};
            shift_d    = word_q[23:16];
            byte_idx_d = byte_idx_q + 2'd1;
            div_d      = c_DIV_LAST;
            txd_d      = 1'b0;
            state_d    = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          div_d = div_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push)
      mem_q[wr_ptr_q] <= bus.nonce;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      word_q     <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      div_q      <= '0;
      txd_q      <= 1'b1;
    end else begin
      if (w_push)
        wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
      if (w_pop)
        rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
      if (w_drop)
        overflow_q <= 1'b1;
      count_q    <= count_d;
      state_q    <= state_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      txd_q      <= txd_d;
    end
  end

  assign bus.txd        = txd_q;
  assign bus.busy       = !w_empty || (state_q != S_IDLE);
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = count_q;
endmodule
`default_nettype wire
